// File: rtl/rs_chien_forney_par_if.sv
`default_nettype none
// ============================================================================
// Module   : rs_chien_forney_par_if
// Purpose  : Request/result bundle for the parallel Chien search / Forney
//            evaluator. The requester drives a one-cycle start together with
//            the error-locator (lambda) and error-evaluator (omega)
//            coefficients. The evaluator returns one registered chunk of P
//            lane results per cycle, followed by a done pulse that carries
//            the final root count and the decoder-failure flag.
// Ports    : master - start, lambda, omega out; all results in
//            slave  - start, lambda, omega in; busy, out_valid, out_chunk,
//                     err_mask, err_data, done, err_cnt, fail out
// Revision : 1.0 - initial release
// ============================================================================
interface rs_chien_forney_par_if #(
  parameter int T = 2,
  parameter int P = 8,
  parameter int N = 198
);
  localparam int K   = (N + P - 1) / P;
  localparam int CHW = (K > 1) ? $clog2(K) : 1;
  localparam int ECW = $clog2(N + 1);

  logic                 start;
  logic [8*(T+1)-1:0]   lambda;
  logic [8*T-1:0]       omega;
  logic                 busy;
  logic                 out_valid;
  logic [CHW-1:0]       out_chunk;
  logic [P-1:0]         err_mask;
  logic [8*P-1:0]       err_data;
  logic                 done;
  logic [ECW-1:0]       err_cnt;
  logic                 fail;

  modport master (
    output start, lambda, omega,
    input  busy, out_valid, out_chunk, err_mask, err_data, done, err_cnt, fail
  );

  modport slave (
    input  start, lambda, omega,
    output busy, out_valid, out_chunk, err_mask, err_data, done, err_cnt, fail
  );
endinterface
`default_nettype wire

// File: rtl/rs_chien_forney_par.sv
`default_nettype none
// ============================================================================
// Module   : rs_chien_forney_par
// Purpose  : P-lane parallel Chien search with Forney error-value evaluation
//            over GF(2^8) (primitive polynomial 0x11D). Position i of an
//            N-symbol codeword is evaluated at x = alpha^(EXP0+i); P positions
//            are handled per cycle, so a search takes K = ceil(N/P) cycles.
// Ports    : clk  - clock, all state updates on the rising edge
//            rstn - asynchronous active-low reset
//            bus  - slave side of rs_chien_forney_par_if:
//                   start/lambda/omega   request and coefficients
//                   busy                 search in progress
//                   out_valid/out_chunk  registered chunk result strobe/index
//                   err_mask/err_data    per-lane error flags and values
//                   done/err_cnt/fail    completion pulse, root count, failure
// Revision : 1.0 - initial release
// ============================================================================
module rs_chien_forney_par #(
  parameter int T    = 2,
  parameter int P    = 8,
  parameter int N    = 198,
  parameter int EXP0 = 58
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  rs_chien_forney_par_if.slave   bus
);

  localparam int K   = (N + P - 1) / P;
  localparam int CHW = (K > 1) ? $clog2(K) : 1;
  // Chunk counter must also hold K itself (the "all chunks done" value).
  localparam int CNW = $clog2(K + 1);
  localparam int ECW = $clog2(N + 1);
  localparam int PCW = $clog2(P + 1);
  localparam int DW  = (T > 0) ? $clog2(T + 1) : 1;

  // --------------------------------------------------------------------------
  // GF(2^8) arithmetic, primitive polynomial x^8+x^4+x^3+x^2+1
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // Elaboration-time only: alpha^e for building constant multipliers.
  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // a^-1 = a^254 = a^(2+4+...+128); maps 0 to 0, which gives the required
  // zero error value when the Forney denominator vanishes.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // r_lterm[k] = lambda_k * alpha^(k*(EXP0 + c*P)) for the chunk c being
  // evaluated; lane j only needs one more constant factor alpha^(k*j).
  logic [7:0]       r_lterm [T+1];
  logic [7:0]       r_oterm [T];
  logic [DW-1:0]    r_deg;
  logic             r_lam_nz;
  logic [CNW-1:0]   r_chunk;

  logic             r_out_valid;
  logic [CHW-1:0]   r_out_chunk;
  logic [P-1:0]     r_err_mask;
  logic [8*P-1:0]   r_err_data;
  logic [ECW-1:0]   r_err_cnt;
  logic             r_fail;

  logic             w_accept;
  logic             w_eval;
  logic [7:0]       w_lterm_init [T+1];
  logic [7:0]       w_lterm_step [T+1];
  logic [7:0]       w_oterm_init [T];
  logic [7:0]       w_oterm_step [T];
  logic [DW-1:0]    w_deg_in;
  logic             w_nz_in;
  logic [P-1:0]     w_mask;
  logic [8*P-1:0]   w_data;
  logic [PCW-1:0]   w_pop;
  logic [ECW:0]     w_cnt_sum;
  logic [ECW-1:0]   w_cnt_nxt;
  logic             w_fail;

  assign w_accept = bus.start && (r_state == S_IDLE);
  // RUN lasts K+1 cycles: K evaluation cycles, then one cycle in which the
  // last registered chunk is presented and the failure flag is resolved.
  assign w_eval   = (r_state == S_RUN) && (r_chunk != CNW'(K));

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (!w_eval)   w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-coefficient seed (position 0) and per-chunk step (P positions)
  // --------------------------------------------------------------------------
  for (genvar k = 0; k <= T; k++) begin : g_lcoef
    localparam logic [7:0] c_init = gf_alpha_pow(k * EXP0);
    localparam logic [7:0] c_step = gf_alpha_pow(k * P);
    assign w_lterm_init[k] = gf_mul(bus.lambda[8*k +: 8], c_init);
    assign w_lterm_step[k] = gf_mul(r_lterm[k], c_step);
  end

  for (genvar k = 0; k < T; k++) begin : g_ocoef
    localparam logic [7:0] c_init = gf_alpha_pow(k * EXP0);
    localparam logic [7:0] c_step = gf_alpha_pow(k * P);
    assign w_oterm_init[k] = gf_mul(bus.omega[8*k +: 8], c_init);
    assign w_oterm_step[k] = gf_mul(r_oterm[k], c_step);
  end

  // Degree of the incoming locator, captured with the coefficients.
  always_comb begin
    w_deg_in = '0;
    w_nz_in  = 1'b0;
    for (int k = 0; k <= T; k++) begin
      if (bus.lambda[8*k +: 8] != 8'h00) begin
        w_deg_in = DW'(k);
        w_nz_in  = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lane evaluation
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < P; j++) begin : g_lane
    logic [7:0] w_lt [T+1];
    logic [7:0] w_ot [T];
    logic [7:0] w_lam_val;
    logic [7:0] w_den;
    logic [7:0] w_omg_val;
    logic       w_in_range;
    logic       w_hit;

    for (genvar k = 0; k <= T; k++) begin : g_lt
      localparam logic [7:0] c_rot = gf_alpha_pow(k * j);
      assign w_lt[k] = gf_mul(r_lterm[k], c_rot);
    end

    for (genvar k = 0; k < T; k++) begin : g_ot
      localparam logic [7:0] c_rot = gf_alpha_pow(k * j);
      assign w_ot[k] = gf_mul(r_oterm[k], c_rot);
    end

    // The odd-power terms of Lambda(x) form x*Lambda'(x) in characteristic 2.
    always_comb begin
      w_lam_val = 8'h00;
      w_den     = 8'h00;
      for (int k = 0; k <= T; k++) begin
        w_lam_val = w_lam_val ^ w_lt[k];
        if ((k % 2) == 1) w_den = w_den ^ w_lt[k];
      end
    end

    always_comb begin
      w_omg_val = 8'h00;
      for (int k = 0; k < T; k++) begin
        w_omg_val = w_omg_val ^ w_ot[k];
      end
    end

    // Lanes past the codeword end in the final chunk are never flagged.
    assign w_in_range = (int'(r_chunk) * P + j) < N;
    assign w_hit      = w_eval && r_lam_nz && (w_lam_val == 8'h00) && w_in_range;

    assign w_mask[j]              = w_hit;
    assign w_data[8*(P-1-j) +: 8] = w_hit ? gf_mul(w_omg_val, gf_inv(w_den)) : 8'h00;
  end

  // --------------------------------------------------------------------------
  // Root count accumulation (saturating) and failure decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_pop = '0;
    for (int j = 0; j < P; j++) begin
      w_pop = w_pop + PCW'(w_mask[j]);
    end
  end

  always_comb begin
    w_cnt_sum = {1'b0, r_err_cnt} + (ECW+1)'(w_pop);
    w_cnt_nxt = w_cnt_sum[ECW] ? {ECW{1'b1}} : w_cnt_sum[ECW-1:0];
  end

  assign w_fail = !r_lam_nz || (32'(r_err_cnt) > T) || (32'(r_err_cnt) != 32'(r_deg));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      for (int k = 0; k <= T; k++) r_lterm[k] <= 8'h00;
      for (int k = 0; k < T; k++)  r_oterm[k] <= 8'h00;
      r_deg       <= '0;
      r_lam_nz    <= 1'b0;
      r_chunk     <= '0;
      r_out_valid <= 1'b0;
      r_out_chunk <= '0;
      r_err_mask  <= '0;
      r_err_data  <= '0;
      r_err_cnt   <= '0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // w_mask/w_data are already zero whenever no chunk is being evaluated.
      r_out_valid <= w_eval;
      r_out_chunk <= w_eval ? CHW'(r_chunk) : '0;
      r_err_mask  <= w_mask;
      r_err_data  <= w_data;

      if (w_accept) begin
        for (int k = 0; k <= T; k++) r_lterm[k] <= w_lterm_init[k];
        for (int k = 0; k < T; k++)  r_oterm[k] <= w_oterm_init[k];
        r_deg     <= w_deg_in;
        r_lam_nz  <= w_nz_in;
        r_chunk   <= '0;
        r_err_cnt <= '0;
        r_fail    <= 1'b0;
      end else if (w_eval) begin
        for (int k = 0; k <= T; k++) r_lterm[k] <= w_lterm_step[k];
        for (int k = 0; k < T; k++)  r_oterm[k] <= w_oterm_step[k];
        r_chunk   <= r_chunk + CNW'(1);
        r_err_cnt <= w_cnt_nxt;
      end else if (r_state == S_RUN) begin
        // Count is final here; the flag becomes visible with done.
        r_fail    <= w_fail;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_LAST);
  assign bus.out_valid = r_out_valid;
  assign bus.out_chunk = r_out_chunk;
  assign bus.err_mask  = r_err_mask;
  assign bus.err_data  = r_err_data;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.fail      = r_fail;

endmodule
`default_nettype wire

// File: doc/rs_chien_forney_par.md
RS_CHIEN_FORNEY_PAR -- requirements
Module: rs_chien_forney_par

Interface
REQ-001 Parameter T, default 2: correction capability; Λ has degree ≤T and Ω has degree ≤T-1.
REQ-002 Parameter P, default 8: positions evaluated per cycle (lanes).
REQ-003 Parameter N, default 198: codeword length in symbols.
REQ-004 Parameter EXP0, default 58: position i (0..N-1) is evaluated at x = α^(EXP0+i) over GF(2^8), primitive polynomial 0x11D.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request; Λ and Ω are sampled on the same cycle.
REQ-008 lambda  input  8*(T+1)  Λ coefficients; byte k = λk, with λ0 in bits [7:0].
REQ-009 omega  input  8*T  Ω coefficients; byte k = Ωk.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 out_valid  output  1  the current chunk result is valid.
REQ-012 out_chunk  output  clog2(ceil(N/P))  index of the chunk being presented.
REQ-013 err_mask  output  P  lane j set means position out_chunk*P+j is in error.
REQ-014 err_data  output  8*P  error value per lane, lane 0 in the MSB byte; lanes with a clear mask are zero.
REQ-015 done  output  1  one-cycle pulse when the search completes.
REQ-016 err_cnt  output  clog2(N+1)  number of roots found.
REQ-017 fail  output  1  decoder-failure flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and LAST. start in IDLE -> RUN; RUN -> LAST after the final chunk is evaluated; LAST -> IDLE.
REQ-019 In IDLE, start SHALL latch lambda and omega into internal registers; start in any other state SHALL be ignored.
REQ-020 In RUN, chunk c (0..K-1, K=ceil(N/P)) SHALL be evaluated in the c-th RUN cycle; the evaluation term per coefficient advances by α^(k·P) each cycle.
REQ-021 Each result SHALL be registered: out_valid, out_chunk, err_mask and err_data are presented one cycle after evaluation, so the first out_valid occurs 2 cycles after start.
REQ-022 A lane SHALL be flagged when Λ(x)=0 and its position is < N; lanes with position ≥ N in the last chunk SHALL be masked to 0.
REQ-023 Error value (Forney, characteristic 2) SHALL be Ω(x) · inv(Σ over odd k of λk·x^k); if the denominator is 0, the value SHALL be 0 and the mask bit still set.
REQ-024 err_cnt SHALL accumulate popcount(mask) per chunk, saturating at 2^width-1.
REQ-025 done SHALL pulse in the LAST cycle, one cycle after the last out_valid; err_cnt and fail SHALL be valid from that cycle and held until the next accepted start.
REQ-026 fail SHALL be 1 when err_cnt > T or err_cnt ≠ deg(Λ), where deg(Λ) is the highest k with λk ≠ 0.
REQ-027 An accepted start SHALL clear err_cnt and fail in the same cycle it latches the coefficients.
REQ-028 Outside RUN/LAST, out_valid SHALL be 0, and err_mask and err_data SHALL be 0.
REQ-029 Λ = 0 (all coefficients zero) SHALL not flag any position and SHALL set fail = 1 at done.
REQ-030 start asserted in the same cycle as done SHALL be ignored; a new start is accepted only from IDLE.

Reset
REQ-031 When rstn is low, all state SHALL asynchronously reset: FSM in IDLE, coefficient registers, err_cnt, fail, busy, out_valid and done at 0, and err_mask, err_data and out_chunk at 0.
REQ-032 Reset asserted mid-RUN SHALL abort the search; after rstn rises, no done pulse is produced until a new start.

Verification (T=2, P=8, N=198, EXP0=58, K=25)
REQ-033 lambda = {0,0,1}, omega = 0, start at cycle 0 -> out_valid in cycles 2..26 with all masks 0; done in cycle 27; err_cnt = 0; fail = 0.
REQ-034 λ0 = 1, λ1 = α^187, λ2 = 0, Ω0 = 0x5A, Ω1 = 0 -> only out_chunk = 1 has err_mask bit 2 set, and that lane's err_data = 0x5A; err_cnt = 1; fail = 0.
REQ-035 lambda = {1,0,1} (Λ = (1+x)^2) -> only position 197 (chunk 24, lane 5) is flagged; lanes 6 and 7 of chunk 24 are masked; err_cnt = 1; fail = 1.
REQ-036 start re-pulsed in cycle 5 with different coefficients -> ignored; results match the first request; done still in cycle 27.
REQ-037 rstn pulsed low in cycle 10 -> all outputs are 0 immediately, no done follows, and a subsequent start runs normally.
